// File: rtl/seq_detector_p_if.sv
// Signal bundle for the serial pattern detector: serial input, configuration
// load, and match status. The bench or upstream logic is master, the detector is slave.
interface seq_detector_p_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
);
  logic               din;
  logic               din_vld;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               cnt_clr;
  logic               flag;
  logic               flag_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output din, din_vld, cfg_load, pattern, pat_len, overlap, cnt_clr,
    input  flag, flag_q, match_cnt, cfg_err
  );

  modport slave (
    input  din, din_vld, cfg_load, pattern, pat_len, overlap, cnt_clr,
    output flag, flag_q, match_cnt, cfg_err
  );
endinterface

// File: rtl/seq_detector_p.sv
// Runtime-configurable serial pattern detector with overlapping or non-overlapping
// matching, a Mealy match flag, its registered copy and a saturating match counter.
module seq_detector_p #(
  parameter int                 MAX_LEN = 16,
  parameter int                 LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(16'h00AA),
  parameter int                 RST_LEN = 8,
  parameter bit                 RST_OVL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active low
  seq_detector_p_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic             RST_ERR  = (RST_LEN == 0) || (RST_LEN > MAX_LEN);

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic               err_r;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               flag_q_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               accepted;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               match;
  logic               flag_c;
  logic               load_err;

  assign accepted = bus.din_vld & ~bus.cfg_load;
  assign cand     = {hist[MAX_LEN-2:0], bus.din};
  assign fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
  assign load_err = (bus.pat_len == '0) || (int'(bus.pat_len) > MAX_LEN);

  // Only the low len_r bits of the candidate take part in the comparison.
  // NOTE: every always_comb output gets a default before the loop, so no latch can be inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_r));
    end
  end

  assign match  = !err_r && (fill_inc >= {1'b0, len_r}) && (((cand ^ pat_r) & mask) == '0);
  assign flag_c = accepted & match;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r <= RST_PAT;
      len_r <= LEN_W'(RST_LEN);
      ovl_r <= RST_OVL;
      err_r <= RST_ERR;
      hist  <= '0;
      fill  <= '0;
    end else if (bus.cfg_load) begin
      pat_r <= bus.pattern;
      len_r <= bus.pat_len;
      ovl_r <= bus.overlap;
      err_r <= load_err;
      hist  <= '0;
      fill  <= '0;
    end else if (accepted) begin
      if (match && !ovl_r) begin
        // Non-overlapping: the bits of this match cannot seed the next one.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= cand;
        fill <= (fill == FILL_MAX) ? fill : fill_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      flag_q_r <= flag_c;
      if (bus.cnt_clr) begin
        cnt_r <= '0;
      end else if (flag_c && cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.flag      = flag_c;
  assign bus.flag_q    = flag_q_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cfg_err   = err_r;

endmodule

// File: tb/tb_seq_detector_p.sv
// Directed bench for seq_detector_p: a default-width instance and a CNT_W=2
// instance share one stimulus stream; expected flags are hand-derived per bit.
module tb_seq_detector_p;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;
  int   exp_cnt2;

  seq_detector_p_if #(.MAX_LEN(16), .CNT_W(8)) bus  ();
  seq_detector_p_if #(.MAX_LEN(16), .CNT_W(2)) bus2 ();

  seq_detector_p #(.MAX_LEN(16), .CNT_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_detector_p #(.MAX_LEN(16), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.din      = bus.din;
  assign bus2.din_vld  = bus.din_vld;
  assign bus2.cfg_load = bus.cfg_load;
  assign bus2.pattern  = bus.pattern;
  assign bus2.pat_len  = bus.pat_len;
  assign bus2.overlap  = bus.overlap;
  assign bus2.cnt_clr  = bus.cnt_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One cycle of stimulus; exp_flag is the hand-computed Mealy output for it.
  task automatic send(input logic b, input logic vld, input logic clr,
                      input logic exp_flag, input string tag);
    @(negedge clk);
    bus.din      = b;
    bus.din_vld  = vld;
    bus.cnt_clr  = clr;
    bus.cfg_load = 1'b0;
    #1 check({tag, " flag"}, int'(bus.flag), int'(exp_flag));
    check({tag, " flag2"}, int'(bus2.flag), int'(exp_flag));
    if (clr) begin
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end else if (exp_flag) begin
      if (exp_cnt  < 255) exp_cnt++;
      if (exp_cnt2 < 3)   exp_cnt2++;
    end
    @(posedge clk);
    #1 check({tag, " flag_q"}, int'(bus.flag_q), int'(exp_flag));
    check({tag, " cnt"},  int'(bus.match_cnt),  exp_cnt);
    check({tag, " cnt2"}, int'(bus2.match_cnt), exp_cnt2);
    bus.din_vld = 1'b0;
    bus.cnt_clr = 1'b0;
  endtask

  // Sends n bits MSB first; flags[k] is the expected flag for bits[k].
  task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] flags,
                        input bit gaps, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b1, 1'b0, flags[i], $sformatf("%s b%0d", tag, n - i));
      if (gaps) send(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s gap%0d", tag, n - i));
    end
  endtask

  task automatic load(input logic [15:0] pat, input int len, input logic ovl,
                      input logic b, input logic exp_err, input string tag);
    @(negedge clk);
    bus.cfg_load = 1'b1;
    bus.din      = b;
    bus.din_vld  = 1'b1;
    bus.pattern  = pat;
    bus.pat_len  = 5'(len);
    bus.overlap  = ovl;
    #1 check({tag, " flag"}, int'(bus.flag), 0);
    @(posedge clk);
    #1 check({tag, " flag_q"}, int'(bus.flag_q), 0);
    check({tag, " cnt"}, int'(bus.match_cnt), exp_cnt);
    check({tag, " cfg_err"}, int'(bus.cfg_err), int'(exp_err));
    bus.cfg_load = 1'b0;
    bus.din_vld  = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    #1 check({tag, " cnt"}, int'(bus.match_cnt), 0);
    check({tag, " flag_q"}, int'(bus.flag_q), 0);
    check({tag, " cfg_err"}, int'(bus.cfg_err), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_cnt      = 0;
    exp_cnt2     = 0;
    rst          = 1'b0;
    bus.din      = 1'b0;
    bus.din_vld  = 1'b0;
    bus.cfg_load = 1'b0;
    bus.pattern  = '0;
    bus.pat_len  = '0;
    bus.overlap  = 1'b0;
    bus.cnt_clr  = 1'b0;
    #12;
    check("rst cnt", int'(bus.match_cnt), 0);
    check("rst flag_q", int'(bus.flag_q), 0);
    check("rst cfg_err", int'(bus.cfg_err), 0);
    check("rst flag", int'(bus.flag), 0);
    @(negedge clk);
    rst = 1'b1;

    // Default 1010_1010 with overlap: matches on bits 8, 10, 12.
    stream(32'b1010_1010_1010, 12, 32'b0000_0001_0101, 1'b0, "dflt");

    // 110, non-overlapping, din_vld low every other cycle.
    load(16'b0110, 3, 1'b0, 1'b1, 1'b0, "ld110");
    send(1'b0, 1'b0, 1'b1, 1'b0, "clr0");
    stream(32'b110110, 6, 32'b001001, 1'b1, "p110");

    // 11 without and with overlap.
    load(16'b11, 2, 1'b0, 1'b1, 1'b0, "ld11n");
    stream(32'b1111, 4, 32'b0101, 1'b0, "p11n");
    load(16'b11, 2, 1'b1, 1'b1, 1'b0, "ld11o");
    stream(32'b1111, 4, 32'b0111, 1'b0, "p11o");

    // Single-bit pattern: narrow counter saturates, clear beats a match.
    load(16'b1, 1, 1'b1, 1'b0, 1'b0, "ld1");
    send(1'b0, 1'b0, 1'b1, 1'b0, "clr1");
    stream(32'hFF, 8, 32'hFF, 1'b0, "sat");
    send(1'b1, 1'b1, 1'b1, 1'b1, "clrwin");

    // Illegal lengths report no matches; a legal reload resumes matching.
    load(16'hFFFF, 0, 1'b1, 1'b1, 1'b1, "ld0");
    stream(32'b1111, 4, 32'b0000, 1'b0, "err0");
    load(16'hFFFF, 17, 1'b1, 1'b1, 1'b1, "ld17");
    stream(32'b1111, 4, 32'b0000, 1'b0, "err17");
    load(16'b1001, 4, 1'b0, 1'b1, 1'b0, "ld4");
    stream(32'b1001, 4, 32'b0001, 1'b0, "p1001");

    // Reset mid-stream discards the partial 1010101.
    pulse_reset("rst1");
    stream(32'b1010101, 7, 32'b0, 1'b0, "pre");
    pulse_reset("rst2");
    send(1'b0, 1'b1, 1'b0, 1'b0, "post0");
    stream(32'b1010_1010, 8, 32'b0000_0001, 1'b0, "post");

    // cfg_load on the would-be matching bit suppresses it and clears history.
    pulse_reset("rst3");
    stream(32'b1010101, 7, 32'b0, 1'b0, "ldm");
    load(16'h00AA, 8, 1'b1, 1'b0, 1'b0, "ldhit");
    send(1'b0, 1'b1, 1'b0, 1'b0, "ldm0");
    stream(32'b1010_1010, 8, 32'b0000_0001, 1'b0, "ldm2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
